// File: rtl/plic_irq_gateway.sv
// Per-source interrupt gateway in front of the PLIC: level/edge qualification,
// saturating edge-pending counter, one outstanding request per line until complete.
module plic_irq_gateway #(
  parameter int                     NUM_SOURCES    = 4,
  parameter int                     PLIC_NUM_LINES = 32,
  parameter int                     LINE_OFFSET    = 1,
  parameter logic [NUM_SOURCES-1:0] EDGE_MASK      = '0,
  parameter int                     MAX_PENDING    = 7
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic [NUM_SOURCES-1:0]            irq_src_i,
  input  logic                              claim_valid_i,
  input  logic [$clog2(PLIC_NUM_LINES)-1:0] claim_id_i,
  input  logic                              complete_valid_i,
  input  logic [$clog2(PLIC_NUM_LINES)-1:0] complete_id_i,
  output logic [PLIC_NUM_LINES-1:0]         plic_irq_o,
  output logic [NUM_SOURCES-1:0]            overflow_o
);

  localparam int IDW = $clog2(PLIC_NUM_LINES);
  localparam int CW  = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  if (LINE_OFFSET < 1 || LINE_OFFSET + NUM_SOURCES > PLIC_NUM_LINES) begin : g_bad_map
    $fatal(1, "plic_irq_gateway: source lines do not fit the PLIC vector above line 0");
  end
  if (MAX_PENDING < 1) begin : g_bad_pending
    $fatal(1, "plic_irq_gateway: MAX_PENDING must be at least 1");
  end

  logic [NUM_SOURCES-1:0] prev_q;
  logic [NUM_SOURCES-1:0] req_vec;
  logic [NUM_SOURCES-1:0] ovf_vec;

  // prev resets to 0 so a source held high across reset release counts as one edge
  always_ff @(posedge clock_i) begin
    if (reset_i) prev_q <= '0;
    else         prev_q <= irq_src_i;
  end

  for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_src
    localparam bit             IS_EDGE = EDGE_MASK[k];
    localparam logic [IDW-1:0] LINE_ID = IDW'(LINE_OFFSET + k);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_PENDING);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          ovf_q;
    logic          rise;
    logic          dec;
    logic          start;
    logic          claim_hit;
    logic          complete_hit;

    assign rise         = IS_EDGE & irq_src_i[k] & ~prev_q[k];
    assign dec          = IS_EDGE && (state_q == ST_IDLE) && (cnt_q != '0);
    assign start        = IS_EDGE ? (cnt_q != '0) : irq_src_i[k];
    assign claim_hit    = claim_valid_i && (claim_id_i == LINE_ID);
    assign complete_hit = complete_valid_i && (complete_id_i == LINE_ID);

    // Strobes only act in their own state; claim wins over a same-cycle complete
    // because the complete is only looked at from SERVICE.
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        state_q <= ST_IDLE;
        req_q   <= 1'b0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end
          end
          ST_REQ: begin
            if (claim_hit) begin
              state_q <= ST_SERVICE;
              req_q   <= 1'b0;
            end
          end
          ST_SERVICE: begin
            if (complete_hit) state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        endcase

        if (rise && !dec) begin
          if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
          else                  cnt_q <= cnt_q + CW'(1);
        end else if (dec && !rise) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end

    assign req_vec[k] = req_q;
    assign ovf_vec[k] = ovf_q;
  end

  always_comb begin
    plic_irq_o = '0;
    plic_irq_o[LINE_OFFSET +: NUM_SOURCES] = req_vec;
  end

  assign overflow_o = ovf_vec;

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Directed bench: source 1 edge-triggered, sources 0/2/3 level, lines 1..4.
module tb_plic_irq_gateway;

  logic        clk;
  logic        rst;
  logic [3:0]  src;
  logic        cv;
  logic [4:0]  cid;
  logic        pv;
  logic [4:0]  pid;
  logic [31:0] plic;
  logic [3:0]  ovf;

  int checks = 0;
  int errors = 0;

  plic_irq_gateway #(
    .NUM_SOURCES(4),
    .PLIC_NUM_LINES(32),
    .LINE_OFFSET(1),
    .EDGE_MASK(4'b0010),
    .MAX_PENDING(7)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .irq_src_i(src),
    .claim_valid_i(cv),
    .claim_id_i(cid),
    .complete_valid_i(pv),
    .complete_id_i(pid),
    .plic_irq_o(plic),
    .overflow_o(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic claim(input logic [4:0] id);
    cv = 1'b1; cid = id;
    step();
    cv = 1'b0; cid = '0;
  endtask

  task automatic complete(input logic [4:0] id);
    pv = 1'b1; pid = id;
    step();
    pv = 1'b0; pid = '0;
  endtask

  task automatic pulse1();
    src[1] = 1'b1;
    step();
    src[1] = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; src = 4'hF; cv = 1'b0; cid = '0; pv = 1'b0; pid = '0;

    // Reset with all sources high
    step();
    chk("rst_plic_0", plic, 32'h0);
    chk("rst_ovf_0", {28'b0, ovf}, 32'h0);
    step();
    chk("rst_plic_1", plic, 32'h0);
    rst = 1'b0;
    step();
    chk("rel_level_lines", plic, 32'h0000_001A);
    step();
    chk("rel_edge_line", plic, 32'h0000_001E);
    src = 4'h0;
    for (int id = 1; id <= 4; id++) begin
      claim(5'(id));
      complete(5'(id));
    end
    chk("rel_drained", plic, 32'h0);

    // Level flow on source 3 / line 4
    src[3] = 1'b1;
    step();
    chk("lvl_req", plic, 32'h10);
    step();
    chk("lvl_hold", plic, 32'h10);
    claim(5'd4);
    chk("lvl_claimed", plic, 32'h0);
    step();
    chk("lvl_service_low", plic, 32'h0);
    complete(5'd4);
    chk("lvl_idle_gap", plic, 32'h0);
    step();
    chk("lvl_rereq", plic, 32'h10);
    src[3] = 1'b0;
    claim(5'd4);
    complete(5'd4);
    step();
    chk("lvl_done", plic, 32'h0);

    // Ignored strobes with line 2 in REQ
    pulse1();
    chk("ign_req", plic, 32'h4);
    claim(5'd0);
    chk("ign_claim0", plic, 32'h4);
    claim(5'd31);
    chk("ign_claim31", plic, 32'h4);
    complete(5'd2);
    chk("ign_complete_req", plic, 32'h4);
    claim(5'd2);
    chk("ign_claimed", plic, 32'h0);
    complete(5'd2);
    claim(5'd2);
    chk("ign_claim_idle", plic, 32'h0);
    pulse1();
    chk("ign_req_again", plic, 32'h4);
    claim(5'd2);
    complete(5'd2);
    step();
    chk("ign_done", plic, 32'h0);

    // Three edges before claim -> three requests
    pulse1();
    pulse1();
    pulse1();
    chk("edge3_req", plic, 32'h4);
    for (int r = 0; r < 3; r++) begin
      claim(5'd2);
      chk("edge3_claimed", plic, 32'h0);
      complete(5'd2);
      step();
      chk("edge3_next", plic, (r < 2) ? 32'h4 : 32'h0);
    end
    step();
    chk("edge3_idle", plic, 32'h0);

    // Nine edges, no claim: one in flight, 7 pending, overflow sticky
    for (int p = 0; p < 9; p++) pulse1();
    chk("ovf_req", plic, 32'h4);
    chk("ovf_flag", {28'b0, ovf}, 32'h2);
    for (int r = 0; r < 8; r++) begin
      claim(5'd2);
      complete(5'd2);
      step();
      chk("ovf_round", plic, (r < 7) ? 32'h4 : 32'h0);
    end
    chk("ovf_sticky", {28'b0, ovf}, 32'h2);

    // Reset clears overflow and pending state
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst2_ovf", {28'b0, ovf}, 32'h0);
    chk("rst2_plic", plic, 32'h0);

    // Fill count to 7 while in REQ, then rise on the IDLE->REQ edge
    pulse1();
    for (int p = 0; p < 7; p++) pulse1();
    chk("sim_full_ovf", {28'b0, ovf}, 32'h0);
    claim(5'd2);
    complete(5'd2);
    src[1] = 1'b1;
    step();
    src[1] = 1'b0;
    chk("sim_req", plic, 32'h4);
    chk("sim_no_ovf", {28'b0, ovf}, 32'h0);

    // Claim and complete together while in REQ: claim wins
    cv = 1'b1; cid = 5'd2; pv = 1'b1; pid = 5'd2;
    step();
    cv = 1'b0; pv = 1'b0;
    chk("cc_claimed", plic, 32'h0);
    step();
    chk("cc_in_service", plic, 32'h0);
    complete(5'd2);
    step();
    chk("cc_rereq", plic, 32'h4);
    for (int r = 0; r < 7; r++) begin
      claim(5'd2);
      complete(5'd2);
      step();
      chk("sim_round", plic, (r < 6) ? 32'h4 : 32'h0);
    end
    chk("sim_end_ovf", {28'b0, ovf}, 32'h0);

    // Reset mid-request discards it
    src[0] = 1'b1;
    step();
    chk("mid_req", plic, 32'h2);
    src[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_clear", plic, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
